bombillo_multi: RTL and testbench

BOMBILLO_MULTI -- requirements
Module: bombillo_multi

---
 rtl/bombillo_multi.sv | 216 +++++++++++++++++++++
 tb/tb_bombillo_multi.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bombillo_multi.sv
// bombillo_multi: multi-channel grow-lamp controller.
// Each channel tracks the daily light minutes of one plant and turns a lamp
// on inside the plant's lamp window when natural light is missing.
// Optional feature: define HOLD_MIN_EN to keep a freshly lit lamp on for at
// least HOLD_MIN ticks even if the sun comes back.
module bombillo_multi #(
  parameter int unsigned NCANALES   = 4,
  parameter logic [15:0] LUX_ALTO   = 16'd20000,
  parameter logic [15:0] LUX_BAJO   = 16'd18000,
  parameter logic [9:0]  T_SUC      = 10'd0,
  parameter logic [9:0]  T_LAU      = 10'd240,
  parameter logic [9:0]  T_PAPA     = 10'd480,
  parameter int unsigned H_SOL_INI  = 8,
  parameter int unsigned H_SOL_FIN  = 17,
  parameter int unsigned H_LAU_INI  = 13,
  parameter int unsigned H_PAPA_INI = 9,
  parameter int unsigned H_LAMP_FIN = 17,
  parameter int unsigned HOLD_MIN   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick_min,
  input  logic [4:0]               hora,
  input  logic [16*NCANALES-1:0]   luxes,
  input  logic [4*NCANALES-1:0]    tipoPlanta,
  input  logic [NCANALES-1:0]      MODluz,
  output logic [NCANALES-1:0]      prenderB,
  output logic [NCANALES-1:0]      completo
);

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    SOL      = 2'd1,
    LAMPARA  = 2'd2,
    COMPLETO = 2'd3
  } estado_t;

  localparam logic [4:0] SOL_INI  = 5'(H_SOL_INI);
  localparam logic [4:0] SOL_FIN  = 5'(H_SOL_FIN);
  localparam logic [4:0] LAU_INI  = 5'(H_LAU_INI);
  localparam logic [4:0] PAPA_INI = 5'(H_PAPA_INI);
  localparam logic [4:0] LAMP_FIN = 5'(H_LAMP_FIN);
  localparam logic [9:0] CNT_MAX  = 10'h3FF;

  logic [4:0] prev_hora;
  logic       hora_ok;
  logic       in_sun_win;
  logic       day_reset;

  // Hours above 23 are garbage and fall outside every window.
  assign hora_ok    = (hora <= 5'd23);
  assign in_sun_win = hora_ok && (hora >= SOL_INI) && (hora < SOL_FIN);
  // Midnight is detected as the first tick at hour 0 after a non-zero hour.
  assign day_reset  = (hora == 5'd0) && (prev_hora != 5'd0);

  // Remember the hour seen on the previous tick for midnight detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_hora <= 5'd0;
    end else if (tick_min) begin
      prev_hora <= hora;
    end
  end

  for (genvar i = 0; i < NCANALES; i++) begin : g_ch
    logic [15:0] lux;
    logic [3:0]  tipo;
    logic        mod;
    logic        sun_q, sun_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  target;
    logic [4:0]  lamp_ini;
    logic        lamp_type;
    logic        in_lamp_win;
    logic        hold_ok;
    logic        credit;
    logic        lamp_q, done_q;
    estado_t     state_q, state_pre, state_d;

    assign lux  = luxes[16*i +: 16];
    assign tipo = tipoPlanta[4*i +: 4];
    assign mod  = MODluz[i];

    // Decode the plant type into its daily target and lamp window start.
    always_comb begin
      target    = 10'd0;
      lamp_ini  = 5'd0;
      lamp_type = 1'b0;
      case (tipo)
        4'd1: target = T_SUC;
        4'd2: begin
          target    = T_LAU;
          lamp_ini  = LAU_INI;
          lamp_type = 1'b1;
        end
        4'd3: begin
          target    = T_PAPA;
          lamp_ini  = PAPA_INI;
          lamp_type = 1'b1;
        end
        default: target = 10'd0;
      endcase
    end

    assign in_lamp_win = lamp_type && hora_ok && (hora >= lamp_ini) && (hora < LAMP_FIN);

    // Sun detector with hysteresis so readings near the threshold do not chatter.
    always_comb begin
      sun_d = sun_q;
      if (lux >= LUX_ALTO) begin
        sun_d = 1'b1;
      end else if (lux < LUX_BAJO) begin
        sun_d = 1'b0;
      end
    end

`ifdef HOLD_MIN_EN
    logic [9:0] hold_q;

    assign hold_ok = (hold_q <= 10'd1);

    // Count down the minimum on-time of a lamp that has just been lit.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_q <= 10'd0;
      end else if (tick_min) begin
        if (state_d != LAMPARA) begin
          hold_q <= 10'd0;
        end else if (state_q != LAMPARA) begin
          hold_q <= 10'(HOLD_MIN);
        end else if (hold_q != 10'd0) begin
          hold_q <= hold_q - 10'd1;
        end
      end
    end
`else
    assign hold_ok = 1'b1;
`endif

    // Next state and counter; a minute is credited when the coming minute
    // will be lit (sun in window or lamp chosen), and the target is checked
    // against the credited count so completion and lamp-off coincide.
    always_comb begin
      state_pre = state_q;
      case (state_q)
        ESPERA: begin
          if (sun_d && in_sun_win) begin
            state_pre = SOL;
          end else if (!sun_d && in_lamp_win && (cnt_q < target)) begin
            state_pre = LAMPARA;
          end
        end
        SOL: begin
          if (!sun_d && in_lamp_win && (cnt_q < target)) begin
            state_pre = LAMPARA;
          end else if (!in_sun_win) begin
            state_pre = ESPERA;
          end
        end
        LAMPARA: begin
          if (!in_lamp_win) begin
            state_pre = ESPERA;
          end else if (sun_d && hold_ok) begin
            state_pre = SOL;
          end
        end
        COMPLETO: begin
          if (cnt_q < target) begin
            state_pre = ESPERA;
          end
        end
        default: state_pre = ESPERA;
      endcase

      credit = mod && ((sun_d && in_sun_win) || (state_pre == LAMPARA));
      cnt_d  = cnt_q;
      if (credit && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 10'd1;
      end

      state_d = state_pre;
      if (cnt_d >= target) begin
        state_d = COMPLETO;
      end
      if (!mod) begin
        state_d = ESPERA;
        cnt_d   = cnt_q;
      end
      if (day_reset) begin
        state_d = ESPERA;
        cnt_d   = 10'd0;
      end
    end

    // Register state, counter, sun flag and decoded outputs on minute ticks.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ESPERA;
        cnt_q   <= 10'd0;
        sun_q   <= 1'b0;
        lamp_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (tick_min) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        sun_q   <= sun_d;
        lamp_q  <= (state_d == LAMPARA);
        done_q  <= (state_d == COMPLETO);
      end
    end

    assign prenderB[i] = lamp_q;
    assign completo[i] = done_q;
  end

endmodule

// File: tb/tb_bombillo_multi.sv
// Directed testbench for bombillo_multi with four channels:
// ch0 Papa, ch1 Laurel, ch2 Papa without light module, ch3 Suculenta.
module tb_bombillo_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_min;
  logic [4:0]  hora;
  logic [63:0] luxes;
  logic [15:0] tipoPlanta;
  logic [3:0]  MODluz;
  logic [3:0]  prenderB;
  logic [3:0]  completo;

  int assertions_evaluated = 0;
  int failures = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  bombillo_multi #(.NCANALES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_min   (tick_min),
    .hora       (hora),
    .luxes      (luxes),
    .tipoPlanta (tipoPlanta),
    .MODluz     (MODluz),
    .prenderB   (prenderB),
    .completo   (completo)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertions_evaluated++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Issue n one-clock minute ticks; returns on the falling edge after the
  // last tick so outputs are settled for sampling.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tick_min = 1'b1;
      @(negedge clk);
      tick_min = 1'b0;
    end
  endtask

  initial begin
    rst        = 1'b1;
    tick_min   = 1'b0;
    hora       = 5'd9;
    luxes      = 64'd0;
    tipoPlanta = {4'd1, 4'd3, 4'd2, 4'd3};
    MODluz     = 4'b1011;

    #12;
    checkOutput("reset_state", {24'd0, prenderB, completo}, {24'd0, 4'b0000, 4'b0000});
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("no_tick_after_reset", {24'd0, prenderB, completo}, {24'd0, 4'b0000, 4'b0000});

    applyStimulus(1);
    checkOutput("tick1_papa_on_suc_done", {24'd0, prenderB, completo}, {24'd0, 4'b0001, 4'b1000});

    hora = 5'd10;
    applyStimulus(239);
    checkOutput("laurel_off_at_10", {24'd0, prenderB, completo}, {24'd0, 4'b0001, 4'b1000});

    hora = 5'd13;
    applyStimulus(1);
    checkOutput("laurel_on_at_13", {24'd0, prenderB, completo}, {24'd0, 4'b0011, 4'b1000});

    luxes[31:16] = 16'd19000;
    applyStimulus(1);
    checkOutput("hyst_19000_on", {24'd0, prenderB, completo}, {24'd0, 4'b0011, 4'b1000});
    luxes[31:16] = 16'd20000;
    applyStimulus(1);
    checkOutput("hyst_20000_off", {24'd0, prenderB, completo}, {24'd0, 4'b0001, 4'b1000});
    luxes[31:16] = 16'd18500;
    applyStimulus(1);
    checkOutput("hyst_18500_off", {24'd0, prenderB, completo}, {24'd0, 4'b0001, 4'b1000});
    luxes[31:16] = 16'd17000;
    applyStimulus(1);
    checkOutput("hyst_17000_on", {24'd0, prenderB, completo}, {24'd0, 4'b0011, 4'b1000});

    applyStimulus(234);
    checkOutput("tick479_still_lit", {24'd0, prenderB, completo}, {24'd0, 4'b0011, 4'b1000});
    applyStimulus(1);
    checkOutput("tick480_targets_met", {24'd0, prenderB, completo}, {24'd0, 4'b0000, 4'b1011});

    hora = 5'd23;
    applyStimulus(1);
    checkOutput("hora23_hold_done", {24'd0, prenderB, completo}, {24'd0, 4'b0000, 4'b1011});
    hora = 5'd0;
    applyStimulus(1);
    checkOutput("midnight_reset", {24'd0, prenderB, completo}, {24'd0, 4'b0000, 4'b0000});
    applyStimulus(1);
    checkOutput("second_midnight_tick", {24'd0, prenderB, completo}, {24'd0, 4'b0000, 4'b1000});

    hora = 5'd9;
    applyStimulus(1);
    checkOutput("counter_cleared_papa_on", {24'd0, prenderB, completo}, {24'd0, 4'b0001, 4'b1000});
    applyStimulus(249);
    checkOutput("papa_250_minutes", {24'd0, prenderB, completo}, {24'd0, 4'b0001, 4'b1000});

    tipoPlanta[3:0] = 4'd2;
    applyStimulus(1);
    checkOutput("type_change_completes", {24'd0, prenderB, completo}, {24'd0, 4'b0000, 4'b1001});

    hora = 5'd13;
    applyStimulus(1);
    checkOutput("laurel_lamp_before_rst", {24'd0, prenderB, completo}, {24'd0, 4'b0010, 4'b1001});

    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_immediate", {24'd0, prenderB, completo}, {24'd0, 4'b0000, 4'b0000});
    #4;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_released_no_tick", {24'd0, prenderB, completo}, {24'd0, 4'b0000, 4'b0000});

    applyStimulus(1);
    checkOutput("first_tick_after_rst", {24'd0, prenderB, completo}, {24'd0, 4'b0011, 4'b1000});

    MODluz = 4'b1001;
    applyStimulus(1);
    checkOutput("modluz_off_forces_dark", {24'd0, prenderB, completo}, {24'd0, 4'b0001, 4'b1000});

    MODluz = 4'b1011;
    hora   = 5'd17;
    applyStimulus(1);
    checkOutput("window_end_lamp_off", {24'd0, prenderB, completo}, {24'd0, 4'b0000, 4'b1000});

    hora = 5'd30;
    applyStimulus(1);
    checkOutput("invalid_hour_dark", {24'd0, prenderB, completo}, {24'd0, 4'b0000, 4'b1000});

    $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
    $finish;
  end

endmodule
